// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, in_a, in_b, select, out_ready,
    input  in_ready, out_valid, alu_out, carry, zero, err
  );

  modport slave (
    input  in_valid, in_a, in_b, select, out_ready,
    output in_ready, out_valid, alu_out, carry, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; define ALU_SEQ_MUL_EN to add the
// iterative shift-add multiplier on select 8 (otherwise select 8 is illegal).
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  alu_seq_if.slave bus
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [SHAMT_W-1:0]   sh;
  logic [SHAMT_W:0]     rsh;
  logic [WIDTH:0]       sum, diff, ext_l, ext_r;
  logic signed [WIDTH:0] ext_s;
  logic [WIDTH-1:0]     op_res;
  logic                 op_carry, op_err;

  // Shifts are done one bit wider so the last bit shifted out lands in the extra bit.
  assign sh    = bus.in_b[SHAMT_W-1:0];
  assign rsh   = (SHAMT_W+1)'(WIDTH) - {1'b0, sh};
  assign sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign diff  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
  assign ext_l = {1'b0, bus.in_a} << sh;
  assign ext_r = {bus.in_a, 1'b0} >> sh;
  assign ext_s = $signed({bus.in_a, 1'b0}) >>> sh;

  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_err   = 1'b0;
    case (bus.select)
      4'd0: {op_carry, op_res} = sum;
      4'd1: {op_carry, op_res} = diff;
      4'd2: op_res = bus.in_a & bus.in_b;
      4'd3: op_res = bus.in_a | bus.in_b;
      4'd4: op_res = bus.in_a ^ bus.in_b;
      4'd5: {op_carry, op_res} = ext_l;
      4'd6: {op_res, op_carry} = ext_r;
      4'd7: op_res = (bus.in_a == bus.in_b) ? '0 :
                     (bus.in_a > bus.in_b) ? WIDTH'(1) : WIDTH'(2);
      4'd9: {op_res, op_carry} = ext_s;
      4'd10: op_res = (bus.in_a << sh) | (bus.in_a >> rsh);
      4'd11: op_res = (bus.in_a == bus.in_b) ? '0 :
                      ($signed(bus.in_a) > $signed(bus.in_b)) ? WIDTH'(1) : WIDTH'(2);
      default: op_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    err_d     = err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.select == 4'd8) begin
            state_d   = BUSY;
            alu_out_d = '0;
            carry_d   = 1'b0;
            zero_d    = 1'b0;
            err_d     = 1'b0;
            acc_d     = '0;
            mcand_d   = {{WIDTH{1'b0}}, bus.in_a};
            mplier_d  = bus.in_b;
            cnt_d     = '0;
          end else
`endif
          begin
            state_d   = DONE;
            alu_out_d = op_res;
            carry_d   = op_carry;
            zero_d    = (op_res == '0);
            err_d     = op_err;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
          state_d   = DONE;
          alu_out_d = acc_step[WIDTH-1:0];
          carry_d   = |acc_step[2*WIDTH-1:WIDTH];
          zero_d    = (acc_step[WIDTH-1:0] == '0);
          err_d     = 1'b0;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_out   = alu_out_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule
